// File: rtl/sonar_sweep_sequencer.sv
// Sonar ping sequencer: one transmit burst per beam angle, first-echo time-of-flight capture,
// per-angle result strobe. Define BIDIRECTIONAL_SWEEP_EN for a ping-pong sweep instead of a wrap.
module sonar_sweep_sequencer #(
    parameter int ANGLE_WIDTH   = 8,
    parameter int ANGLE_MIN     = -30,
    parameter int ANGLE_MAX     = 30,
    parameter int ANGLE_STEP    = 10,
    parameter int PERIOD_CYCLES = 16777216,
    parameter int BURST_CYCLES  = 524288,
    parameter int BLANK_CYCLES  = 600000,
    parameter int COUNT_WIDTH   = $clog2(PERIOD_CYCLES)
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic                          enable_in,
    input  logic                          echo_in,
    output logic signed [ANGLE_WIDTH-1:0] beam_angle_out,
    output logic                          burst_active_out,
    output logic                          burst_start_out,
    output logic [COUNT_WIDTH-1:0]        time_since_emission_out,
    output logic                          result_valid_out,
    output logic signed [ANGLE_WIDTH-1:0] result_angle_out,
    output logic [COUNT_WIDTH-1:0]        result_tof_out,
    output logic                          result_hit_out,
    output logic                          sweep_done_out
);

    typedef enum logic [1:0] {StIdle, StBurst, StListen, StReport} state_e;

    localparam logic signed [ANGLE_WIDTH-1:0] AngMin  = ANGLE_WIDTH'(ANGLE_MIN);
    localparam logic signed [ANGLE_WIDTH:0]   AngMaxX = (ANGLE_WIDTH + 1)'(ANGLE_MAX);
    localparam logic signed [ANGLE_WIDTH:0]   StepX   = (ANGLE_WIDTH + 1)'(ANGLE_STEP);
    localparam logic [COUNT_WIDTH-1:0] BurstLast  = COUNT_WIDTH'(BURST_CYCLES - 1);
    localparam logic [COUNT_WIDTH-1:0] BlankStart = COUNT_WIDTH'(BLANK_CYCLES);
    localparam logic [COUNT_WIDTH-1:0] PeriodLast = COUNT_WIDTH'(PERIOD_CYCLES - 1);
    localparam logic [COUNT_WIDTH-1:0] CountOne   = COUNT_WIDTH'(1);
    localparam logic [COUNT_WIDTH-1:0] NoHit      = '1;

    state_e                         state_q, state_d;
    logic [COUNT_WIDTH-1:0]         count_q, count_d;
    logic signed [ANGLE_WIDTH-1:0]  angle_q, angle_d;
    logic                           hit_q, hit_d;
    logic [COUNT_WIDTH-1:0]         tof_q, tof_d;
    logic signed [ANGLE_WIDTH-1:0]  res_angle_q, res_angle_d;
    logic [COUNT_WIDTH-1:0]         res_tof_q, res_tof_d;
    logic                           res_hit_q, res_hit_d;

    logic signed [ANGLE_WIDTH:0]    angle_x, up_x;
    logic signed [ANGLE_WIDTH-1:0]  next_angle;
    logic                           wrap;
    logic                           echo_ok;

`ifdef BIDIRECTIONAL_SWEEP_EN
    localparam logic signed [ANGLE_WIDTH:0] AngMinX = (ANGLE_WIDTH + 1)'(ANGLE_MIN);
    logic                        dir_up_q, dir_up_d;
    logic signed [ANGLE_WIDTH:0] dn_x;
`endif

    // One extra bit so the step past either end cannot overflow the compare.
    always_comb begin
        angle_x = {angle_q[ANGLE_WIDTH-1], angle_q};
        up_x    = angle_x + StepX;
`ifdef BIDIRECTIONAL_SWEEP_EN
        dn_x = angle_x - StepX;
        if (dir_up_q) begin
            wrap       = (up_x > AngMaxX);
            next_angle = wrap ? dn_x[ANGLE_WIDTH-1:0] : up_x[ANGLE_WIDTH-1:0];
        end else begin
            wrap       = (dn_x < AngMinX);
            next_angle = wrap ? up_x[ANGLE_WIDTH-1:0] : dn_x[ANGLE_WIDTH-1:0];
        end
`else
        wrap       = (up_x > AngMaxX);
        next_angle = wrap ? AngMin : up_x[ANGLE_WIDTH-1:0];
`endif
    end

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        angle_d     = angle_q;
        hit_d       = hit_q;
        tof_d       = tof_q;
        res_angle_d = res_angle_q;
        res_tof_d   = res_tof_q;
        res_hit_d   = res_hit_q;
`ifdef BIDIRECTIONAL_SWEEP_EN
        dir_up_d    = dir_up_q;
`endif
        echo_ok = echo_in && (count_q >= BlankStart) && !hit_q;

        unique case (state_q)
            StIdle: begin
                count_d = '0;
                angle_d = AngMin;
`ifdef BIDIRECTIONAL_SWEEP_EN
                dir_up_d = 1'b1;
`endif
                if (enable_in) state_d = StBurst;
            end
            StBurst: begin
                count_d = count_q + CountOne;
                if (count_q == BurstLast) state_d = StListen;
            end
            StListen: begin
                count_d = count_q + CountOne;
                if (echo_ok) begin
                    hit_d = 1'b1;
                    tof_d = count_q;
                end
                // The last window cycle still counts, so fold this cycle's echo into the result.
                if (count_q == PeriodLast) begin
                    state_d     = StReport;
                    count_d     = '0;
                    res_angle_d = angle_q;
                    res_hit_d   = hit_q | echo_ok;
                    res_tof_d   = hit_q ? tof_q : (echo_ok ? count_q : NoHit);
                end
            end
            StReport: begin
                count_d = '0;
                hit_d   = 1'b0;
                tof_d   = '0;
                if (enable_in) begin
                    state_d = StBurst;
                    angle_d = next_angle;
`ifdef BIDIRECTIONAL_SWEEP_EN
                    if (wrap) dir_up_d = ~dir_up_q;
`endif
                end else begin
                    state_d = StIdle;
                    angle_d = AngMin;
`ifdef BIDIRECTIONAL_SWEEP_EN
                    dir_up_d = 1'b1;
`endif
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q     <= StIdle;
            count_q     <= '0;
            angle_q     <= AngMin;
            hit_q       <= 1'b0;
            tof_q       <= '0;
            res_angle_q <= '0;
            res_tof_q   <= '0;
            res_hit_q   <= 1'b0;
`ifdef BIDIRECTIONAL_SWEEP_EN
            dir_up_q    <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            angle_q     <= angle_d;
            hit_q       <= hit_d;
            tof_q       <= tof_d;
            res_angle_q <= res_angle_d;
            res_tof_q   <= res_tof_d;
            res_hit_q   <= res_hit_d;
`ifdef BIDIRECTIONAL_SWEEP_EN
            dir_up_q    <= dir_up_d;
`endif
        end
    end

    always_comb begin
        beam_angle_out          = angle_q;
        burst_active_out        = (state_q == StBurst);
        burst_start_out         = (state_q == StBurst) && (count_q == '0);
        time_since_emission_out = ((state_q == StBurst) || (state_q == StListen)) ? count_q : '0;
        result_valid_out        = (state_q == StReport);
        sweep_done_out          = (state_q == StReport) && wrap;
        result_angle_out        = res_angle_q;
        result_tof_out          = res_tof_q;
        result_hit_out          = res_hit_q;
    end

endmodule

// File: tb/tb_sonar_sweep_sequencer.sv
// Randomized bench for sonar_sweep_sequencer against a ping-level reference model
// (sweep angles listed up front, position within ping as a plain integer).
module tb_sonar_sweep_sequencer;

    localparam int AW     = 8;
    localparam int AMIN   = -30;
    localparam int AMAX   = 30;
    localparam int ASTEP  = 10;
    localparam int PERIOD = 64;
    localparam int BURST  = 8;
    localparam int BLANK  = 12;
    localparam int CW     = 6;
    localparam int ALL1   = (1 << CW) - 1;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 enable;
    logic                 echo;
    logic signed [AW-1:0] beam_angle;
    logic                 burst_active;
    logic                 burst_start;
    logic [CW-1:0]        tse;
    logic                 result_valid;
    logic signed [AW-1:0] result_angle;
    logic [CW-1:0]        result_tof;
    logic                 result_hit;
    logic                 sweep_done;

    always #5 clk = ~clk;

    sonar_sweep_sequencer #(
        .ANGLE_WIDTH  (AW),
        .ANGLE_MIN    (AMIN),
        .ANGLE_MAX    (AMAX),
        .ANGLE_STEP   (ASTEP),
        .PERIOD_CYCLES(PERIOD),
        .BURST_CYCLES (BURST),
        .BLANK_CYCLES (BLANK),
        .COUNT_WIDTH  (CW)
    ) dut (
        .clk_in                 (clk),
        .rst_in                 (rst),
        .enable_in              (enable),
        .echo_in                (echo),
        .beam_angle_out         (beam_angle),
        .burst_active_out       (burst_active),
        .burst_start_out        (burst_start),
        .time_since_emission_out(tse),
        .result_valid_out       (result_valid),
        .result_angle_out       (result_angle),
        .result_tof_out         (result_tof),
        .result_hit_out         (result_hit),
        .sweep_done_out         (sweep_done)
    );

    int n_vec = 0;
    int n_bad = 0;

    int seq[$];
    int n_up;

    // Reference model: m_pos 0..PERIOD-1 is the ping window, PERIOD is the report cycle.
    bit m_active, m_hit, m_fresh;
    int m_pos, m_idx, m_tof;
    int r_angle, r_tof, r_hit;

    bit en;
    int mode;
    int ping_cnt = 0;

    task automatic check_eq(input string tag, input logic signed [31:0] got,
                            input logic signed [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit is_sweep_end();
`ifdef BIDIRECTIONAL_SWEEP_EN
        return (m_idx == n_up - 1) || (m_idx == 0 && !m_fresh);
`else
        return (m_idx == n_up - 1);
`endif
    endfunction

    task automatic model_reset();
        m_active = 0; m_hit = 0; m_fresh = 1;
        m_pos = 0; m_idx = 0; m_tof = 0;
        r_angle = 0; r_tof = 0; r_hit = 0;
    endtask

    task automatic model_step(input bit en_v, input bit echo_v);
        if (!m_active) begin
            if (en_v) begin
                m_active = 1; m_pos = 0; m_hit = 0;
            end
        end else if (m_pos < PERIOD) begin
            if (echo_v && m_pos >= BURST && m_pos >= BLANK && !m_hit) begin
                m_hit = 1;
                m_tof = m_pos;
            end
            m_pos++;
            if (m_pos == PERIOD) begin
                r_angle = seq[m_idx];
                r_hit   = m_hit;
                r_tof   = m_hit ? m_tof : ALL1;
            end
        end else begin
            m_fresh = 0;
            if (en_v) begin
                m_idx = (m_idx + 1) % seq.size();
                m_pos = 0;
                m_hit = 0;
            end else begin
                m_active = 0; m_idx = 0; m_fresh = 1; m_pos = 0;
            end
        end
    endtask

    task automatic check_outputs();
        bit lis, rep;
        lis = m_active && (m_pos < PERIOD);
        rep = m_active && (m_pos == PERIOD);
        check_eq("beam_angle",   beam_angle,   seq[m_idx]);
        check_eq("burst_active", burst_active, lis && m_pos < BURST);
        check_eq("burst_start",  burst_start,  lis && m_pos == 0);
        check_eq("time_counter", tse,          lis ? m_pos : 0);
        check_eq("result_valid", result_valid, rep);
        check_eq("sweep_done",   sweep_done,   rep && is_sweep_end());
        check_eq("result_angle", result_angle, r_angle);
        check_eq("result_tof",   result_tof,   r_tof);
        check_eq("result_hit",   result_hit,   r_hit);
    endtask

    // One clock: check current state, drive inputs for the coming edge, advance the model.
    task automatic tick();
        bit echo_v;
        @(negedge clk);
        check_outputs();
        enable = en;
        if (m_active && m_pos == 0) begin
            mode = (ping_cnt < 5) ? ping_cnt : int'($urandom_range(0, 4));
            ping_cnt++;
        end
        case (mode)
            0:       echo_v = 1'b0;
            1:       echo_v = (m_pos == 5) || (m_pos == 20);
            2:       echo_v = (m_pos == 12);
            3:       echo_v = (m_pos == PERIOD - 1);
            default: echo_v = ($urandom_range(0, 15) == 0);
        endcase
        if (!m_active) echo_v = 1'($urandom_range(0, 1));
        echo = echo_v;
        model_step(en, echo_v);
    endtask

    task automatic async_reset_check();
        @(negedge clk);
        check_outputs();
        #2 rst = 1'b1;
        #1 model_reset();
        check_outputs();
        @(posedge clk);
        #1 check_outputs();
        #1 rst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        for (int a = AMIN; a <= AMAX; a += ASTEP) seq.push_back(a);
        n_up = seq.size();
`ifdef BIDIRECTIONAL_SWEEP_EN
        for (int k = n_up - 2; k >= 1; k--) seq.push_back(seq[k]);
`endif
        rst = 1'b1; enable = 1'b0; echo = 1'b0; en = 1'b0; mode = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 check_outputs();
        @(negedge clk);
        rst = 1'b0;

        // Continuous sweep: covers wrap, first pings use directed echo patterns.
        en = 1'b1;
        repeat (9 * (PERIOD + 1)) tick();

        // Drop enable at counter 30 of the -10 ping; ping must finish then idle.
        found = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (m_active && m_pos == 30 && seq[m_idx] == -10) begin
                en = 1'b0;
                found = 1'b1;
                break;
            end
            tick();
        end
        check_eq("drop_point_found", found, 1);
        repeat (150) tick();

        // Random enable toggling.
        en = 1'b1;
        repeat (1200) begin
            if ($urandom_range(0, 99) == 0) en = !en;
            tick();
        end

        // Asynchronous reset mid-listen, then restart.
        en = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if (m_active && m_pos == 40) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        check_eq("listen_point_found", found, 1);
        async_reset_check();
        repeat (200) tick();

        // Long uninterrupted run for full sweeps in either sweep mode.
        en = 1'b1;
        repeat (15 * (PERIOD + 1)) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
